// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - two-source common data bus arbiter with 2-deep per-source FIFOs
// Round-robin grant between ALU and LSB result queues; one registered broadcast per cycle.
module cdb_arbiter #(
  parameter int ROB_POS_W = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ROB_POS_W-1:0] alu_rob_pos,
  input  logic [DATA_W-1:0]    alu_val,
  input  logic                 alu_jump,
  input  logic [ADDR_W-1:0]    alu_pc,
  input  logic                 lsb_valid,
  output logic                 lsb_ready,
  input  logic [ROB_POS_W-1:0] lsb_rob_pos,
  input  logic [DATA_W-1:0]    lsb_val,
  output logic                 cdb_valid,
  output logic [ROB_POS_W-1:0] cdb_rob_pos,
  output logic [DATA_W-1:0]    cdb_val,
  output logic                 cdb_jump,
  output logic [ADDR_W-1:0]    cdb_pc,
  output logic                 cdb_src,
  output logic [15:0]          conflict_cnt
);

  logic [ROB_POS_W-1:0] alu_pos_q [2];
  logic [DATA_W-1:0]    alu_val_q [2];
  logic                 alu_jump_q [2];
  logic [ADDR_W-1:0]    alu_pc_q [2];
  logic [ROB_POS_W-1:0] lsb_pos_q [2];
  logic [DATA_W-1:0]    lsb_val_q [2];

  logic       alu_rp, alu_wp, lsb_rp, lsb_wp;
  logic [1:0] alu_cnt, lsb_cnt;
  logic       prio;

  logic run, alu_ne, lsb_ne, alu_push, lsb_push, grant_alu, grant_lsb;

  function automatic logic [1:0] next_cnt(input logic [1:0] c, input logic push, input logic pop);
    case ({push, pop})
      2'b10:   next_cnt = c + 2'd1;
      2'b01:   next_cnt = c - 2'd1;
      default: next_cnt = c;
    endcase
  endfunction

  // Ready looks only at the registered count; a pop this cycle does not free a slot early.
  always_comb begin
    run       = rdy && !rollback;
    alu_ne    = (alu_cnt != 2'd0);
    lsb_ne    = (lsb_cnt != 2'd0);
    alu_ready = run && (alu_cnt != 2'd2);
    lsb_ready = run && (lsb_cnt != 2'd2);
    alu_push  = alu_valid && alu_ready;
    lsb_push  = lsb_valid && lsb_ready;
    grant_alu = run && alu_ne && (!lsb_ne || !prio);
    grant_lsb = run && lsb_ne && (!alu_ne || prio);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        alu_pos_q[i]  <= '0;
        alu_val_q[i]  <= '0;
        alu_jump_q[i] <= 1'b0;
        alu_pc_q[i]   <= '0;
        lsb_pos_q[i]  <= '0;
        lsb_val_q[i]  <= '0;
      end
      alu_rp       <= 1'b0;
      alu_wp       <= 1'b0;
      lsb_rp       <= 1'b0;
      lsb_wp       <= 1'b0;
      alu_cnt      <= 2'd0;
      lsb_cnt      <= 2'd0;
      prio         <= 1'b0;
      cdb_valid    <= 1'b0;
      cdb_rob_pos  <= '0;
      cdb_val      <= '0;
      cdb_jump     <= 1'b0;
      cdb_pc       <= '0;
      cdb_src      <= 1'b0;
      conflict_cnt <= 16'd0;
    end else begin
      // Contention is counted even on a flush cycle and survives the flush.
      if (rdy && alu_ne && lsb_ne && conflict_cnt != 16'hFFFF)
        conflict_cnt <= conflict_cnt + 16'd1;
      if (rollback) begin
        alu_rp    <= 1'b0;
        alu_wp    <= 1'b0;
        lsb_rp    <= 1'b0;
        lsb_wp    <= 1'b0;
        alu_cnt   <= 2'd0;
        lsb_cnt   <= 2'd0;
        prio      <= 1'b0;
        cdb_valid <= 1'b0;
      end else if (rdy) begin
        if (alu_push) begin
          alu_pos_q[alu_wp]  <= alu_rob_pos;
          alu_val_q[alu_wp]  <= alu_val;
          alu_jump_q[alu_wp] <= alu_jump;
          alu_pc_q[alu_wp]   <= alu_pc;
          alu_wp             <= ~alu_wp;
        end
        if (lsb_push) begin
          lsb_pos_q[lsb_wp] <= lsb_rob_pos;
          lsb_val_q[lsb_wp] <= lsb_val;
          lsb_wp            <= ~lsb_wp;
        end
        if (grant_alu) alu_rp <= ~alu_rp;
        if (grant_lsb) lsb_rp <= ~lsb_rp;
        alu_cnt   <= next_cnt(alu_cnt, alu_push, grant_alu);
        lsb_cnt   <= next_cnt(lsb_cnt, lsb_push, grant_lsb);
        cdb_valid <= grant_alu || grant_lsb;
        if (grant_alu) begin
          cdb_rob_pos <= alu_pos_q[alu_rp];
          cdb_val     <= alu_val_q[alu_rp];
          cdb_jump    <= alu_jump_q[alu_rp];
          cdb_pc      <= alu_pc_q[alu_rp];
          cdb_src     <= 1'b0;
          prio        <= 1'b1;
        end else if (grant_lsb) begin
          cdb_rob_pos <= lsb_pos_q[lsb_rp];
          cdb_val     <= lsb_val_q[lsb_rp];
          cdb_jump    <= 1'b0;
          cdb_pc      <= '0;
          cdb_src     <= 1'b1;
          prio        <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter
// Directed vector table and corner sequences, then random traffic against a queue-based model.
module tb_cdb_arbiter;

  logic        clk, rst, rdy, rollback;
  logic        alu_valid, alu_ready, alu_jump;
  logic [3:0]  alu_rob_pos, lsb_rob_pos, cdb_rob_pos;
  logic [31:0] alu_val, alu_pc, lsb_val, cdb_val, cdb_pc;
  logic        lsb_valid, lsb_ready;
  logic        cdb_valid, cdb_jump, cdb_src;
  logic [15:0] conflict_cnt;

  int tests = 0;
  int fails = 0;

  cdb_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rob_pos(alu_rob_pos),
    .alu_val(alu_val), .alu_jump(alu_jump), .alu_pc(alu_pc),
    .lsb_valid(lsb_valid), .lsb_ready(lsb_ready), .lsb_rob_pos(lsb_rob_pos), .lsb_val(lsb_val),
    .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos), .cdb_val(cdb_val),
    .cdb_jump(cdb_jump), .cdb_pc(cdb_pc), .cdb_src(cdb_src), .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each source is a bounded queue, the broadcast is whatever was popped.
  typedef struct {
    logic [3:0]  pos;
    logic [31:0] val;
    logic        j;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq_a[$];
  ent_t        mq_l[$];
  bit          m_prio, m_cv, m_src, m_j;
  logic [3:0]  m_pos;
  logic [31:0] m_val, m_pc;
  int          m_conf;

  task automatic model_edge();
    ent_t e;
    int   pick;
    bit   acc_a, acc_l;
    if (rst) begin
      mq_a.delete(); mq_l.delete();
      m_prio = 0; m_cv = 0; m_src = 0; m_pos = 0; m_val = 0; m_j = 0; m_pc = 0; m_conf = 0;
      return;
    end
    if (rdy && mq_a.size() > 0 && mq_l.size() > 0 && m_conf < 65535) m_conf++;
    if (rollback) begin
      mq_a.delete(); mq_l.delete();
      m_prio = 0; m_cv = 0;
      return;
    end
    if (!rdy) return;
    acc_a = alu_valid && mq_a.size() < 2;
    acc_l = lsb_valid && mq_l.size() < 2;
    pick = -1;
    if (mq_a.size() > 0 && mq_l.size() > 0) pick = int'(m_prio);
    else if (mq_a.size() > 0) pick = 0;
    else if (mq_l.size() > 0) pick = 1;
    if (pick == 0) e = mq_a.pop_front();
    else if (pick == 1) e = mq_l.pop_front();
    if (pick >= 0) begin
      m_pos = e.pos; m_val = e.val; m_j = e.j; m_pc = e.pc;
      m_src = (pick == 1);
      m_prio = (pick == 0);
    end
    m_cv = (pick >= 0);
    if (acc_a) mq_a.push_back('{alu_rob_pos, alu_val, alu_jump, alu_pc});
    if (acc_l) mq_l.push_back('{lsb_rob_pos, lsb_val, 1'b0, 32'd0});
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rob_pos = 0; alu_val = 0; alu_jump = 0; alu_pc = 0;
    lsb_valid = 0; lsb_rob_pos = 0; lsb_val = 0;
  endtask

  typedef struct {
    bit          av;
    logic [3:0]  apos;
    logic [31:0] aval;
    bit          aj;
    logic [31:0] apc;
    bit          lv;
    logic [3:0]  lpos;
    logic [31:0] lval;
    bit          e_ar, e_lr, e_cv, e_src;
    logic [3:0]  e_pos;
    logic [31:0] e_val;
    bit          e_j;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[9];
  int   seen_a[$];
  int   seen_l[$];
  int   acc_l[$];

  initial begin
    int   aidx;
    int   nbc;
    bit   saw_block, any_low;
    rst = 1; rdy = 1; rollback = 0;
    idle_inputs();
    tick(); tick();
    rst = 0;
    #1;
    chk("reset_cdb_valid", cdb_valid, 0);
    chk("reset_conflict", conflict_cnt, 0);
    chk("reset_alu_ready", alu_ready, 1);
    chk("reset_lsb_ready", lsb_ready, 1);

    // Single ALU push, LSB push to steer prio back to ALU, then a same-cycle pair.
    vecs[0] = '{1, 4'd3, 32'h55, 1, 32'h100, 0, 4'd0, 32'h0,  1, 1, 0, 0, 4'd0, 32'h0,  0, 32'h0};
    vecs[1] = '{0, 4'd0, 32'h0,  0, 32'h0,   0, 4'd0, 32'h0,  1, 1, 1, 0, 4'd3, 32'h55, 1, 32'h100};
    vecs[2] = '{0, 4'd0, 32'h0,  0, 32'h0,   0, 4'd0, 32'h0,  1, 1, 0, 0, 4'd0, 32'h0,  0, 32'h0};
    vecs[3] = '{0, 4'd0, 32'h0,  0, 32'h0,   1, 4'd5, 32'h77, 1, 1, 0, 0, 4'd0, 32'h0,  0, 32'h0};
    vecs[4] = '{0, 4'd0, 32'h0,  0, 32'h0,   0, 4'd0, 32'h0,  1, 1, 1, 1, 4'd5, 32'h77, 0, 32'h0};
    vecs[5] = '{1, 4'd1, 32'h11, 0, 32'h0,   1, 4'd2, 32'h22, 1, 1, 0, 0, 4'd0, 32'h0,  0, 32'h0};
    vecs[6] = '{0, 4'd0, 32'h0,  0, 32'h0,   0, 4'd0, 32'h0,  1, 1, 1, 0, 4'd1, 32'h11, 0, 32'h0};
    vecs[7] = '{0, 4'd0, 32'h0,  0, 32'h0,   0, 4'd0, 32'h0,  1, 1, 1, 1, 4'd2, 32'h22, 0, 32'h0};
    vecs[8] = '{0, 4'd0, 32'h0,  0, 32'h0,   0, 4'd0, 32'h0,  1, 1, 0, 0, 4'd0, 32'h0,  0, 32'h0};
    for (int i = 0; i < 9; i++) begin
      alu_valid = vecs[i].av; alu_rob_pos = vecs[i].apos; alu_val = vecs[i].aval;
      alu_jump = vecs[i].aj; alu_pc = vecs[i].apc;
      lsb_valid = vecs[i].lv; lsb_rob_pos = vecs[i].lpos; lsb_val = vecs[i].lval;
      #1;
      chk($sformatf("vec%0d_alu_ready", i), alu_ready, vecs[i].e_ar);
      chk($sformatf("vec%0d_lsb_ready", i), lsb_ready, vecs[i].e_lr);
      tick();
      chk($sformatf("vec%0d_cdb_valid", i), cdb_valid, vecs[i].e_cv);
      if (vecs[i].e_cv) begin
        chk($sformatf("vec%0d_src", i), cdb_src, vecs[i].e_src);
        chk($sformatf("vec%0d_pos", i), cdb_rob_pos, vecs[i].e_pos);
        chk($sformatf("vec%0d_val", i), cdb_val, vecs[i].e_val);
        chk($sformatf("vec%0d_jump", i), cdb_jump, vecs[i].e_j);
        chk($sformatf("vec%0d_pc", i), cdb_pc, vecs[i].e_pc);
      end
    end
    idle_inputs();
    chk("pair_conflict_cnt", conflict_cnt, 1);

    // Three ALU entries against a continuously fed LSB queue.
    aidx = 0; saw_block = 0;
    for (int c = 0; c < 16; c++) begin
      alu_valid = (aidx < 3); alu_rob_pos = 4'(10 + aidx); alu_val = 32'(100 + aidx);
      lsb_valid = (c < 6); lsb_rob_pos = 4'(c); lsb_val = 32'(200 + c);
      #1;
      if (!alu_ready) saw_block = 1;
      if (alu_valid && alu_ready) aidx++;
      if (lsb_valid && lsb_ready) acc_l.push_back(c);
      tick();
      if (cdb_valid) begin
        if (cdb_src) seen_l.push_back(int'(cdb_rob_pos));
        else seen_a.push_back(int'(cdb_rob_pos));
      end
    end
    idle_inputs();
    chk("full_alu_ready_dropped", saw_block, 1);
    chk("full_alu_count", seen_a.size(), 3);
    for (int k = 0; k < seen_a.size() && k < 3; k++)
      chk($sformatf("full_alu_order%0d", k), seen_a[k], 10 + k);
    chk("full_lsb_count", seen_l.size(), acc_l.size());
    for (int k = 0; k < seen_l.size() && k < acc_l.size(); k++)
      chk($sformatf("full_lsb_order%0d", k), seen_l[k], acc_l[k]);

    // Fill both queues as far as they go, then flush: nothing queued may come out.
    for (int c = 0; c < 4; c++) begin
      alu_valid = 1; alu_rob_pos = 4'(8 + c); lsb_valid = 1; lsb_rob_pos = 4'(12 + c);
      tick();
    end
    #1;
    any_low = !alu_ready || !lsb_ready;
    chk("prefill_queue_full", any_low, 1);
    rollback = 1;
    tick();
    chk("rollback_cdb_valid", cdb_valid, 0);
    rollback = 0;
    idle_inputs();
    #1;
    chk("rollback_alu_ready", alu_ready, 1);
    chk("rollback_lsb_ready", lsb_ready, 1);
    nbc = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (cdb_valid) nbc++;
    end
    chk("rollback_no_broadcast", nbc, 0);

    // Stall with one entry queued.
    alu_valid = 1; alu_rob_pos = 4'd7; alu_val = 32'hABCD; alu_jump = 1; alu_pc = 32'h200;
    tick();
    idle_inputs();
    rdy = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d_alu_ready", c), alu_ready, 0);
      tick();
      chk($sformatf("stall%0d_cdb_valid", c), cdb_valid, 0);
    end
    rdy = 1;
    tick();
    chk("stall_release_valid", cdb_valid, 1);
    chk("stall_release_pos", cdb_rob_pos, 7);
    chk("stall_release_val", cdb_val, 32'hABCD);
    chk("stall_release_pc", cdb_pc, 32'h200);
    tick();

    // Reset beats rollback and live inputs.
    rst = 1; rollback = 1; alu_valid = 1; lsb_valid = 1; alu_rob_pos = 4'hF; lsb_rob_pos = 4'hE;
    tick();
    chk("rst_cdb_valid", cdb_valid, 0);
    chk("rst_cdb_payload", {cdb_rob_pos, cdb_val, cdb_jump, cdb_src}, 0);
    chk("rst_cdb_pc", cdb_pc, 0);
    chk("rst_conflict", conflict_cnt, 0);
    rst = 0; rollback = 0;
    idle_inputs();
    #1;
    chk("rst_readies", {alu_ready, lsb_ready}, 2'b11);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom % 700 == 0);
      rdy = ($urandom % 6 != 0);
      rollback = ($urandom % 50 == 0);
      alu_valid = $urandom % 2; alu_rob_pos = 4'($urandom); alu_val = $urandom;
      alu_jump = $urandom % 2; alu_pc = $urandom;
      lsb_valid = $urandom % 2; lsb_rob_pos = 4'($urandom); lsb_val = $urandom;
      #1;
      if (!rst) begin
        chk("rnd_alu_ready", alu_ready, rdy && !rollback && mq_a.size() < 2);
        chk("rnd_lsb_ready", lsb_ready, rdy && !rollback && mq_l.size() < 2);
      end
      tick();
      chk("rnd_cdb_valid", cdb_valid, m_cv);
      chk("rnd_conflict", conflict_cnt, 16'(m_conf));
      if (m_cv) chk("rnd_payload", {cdb_src, cdb_rob_pos, cdb_val, cdb_jump, cdb_pc[26:0]},
                    {m_src, m_pos, m_val, m_j, m_pc[26:0]});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
